// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC owner and instruction fetch FIFO feeding decode over valid/ready.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic out_valid,
    input  logic out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    logic [31:0] pc;
    logic [31:0] q_pc [QUEUE_DEPTH];
    logic [31:0] q_instr [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic pop, push;
    // depth is a power of two, so the top count bit alone marks a full queue
    always_comb begin
        pop = out_valid & out_ready;
        push = fetch_en & (~count[AW] | pop) & ~redirect_valid;
        imem_addr = {2'b00, pc[31:2]};
        out_valid = count != '0;
        out_pc = out_valid ? q_pc[rd_ptr] : 32'h0;
        out_instr = out_valid ? q_instr[rd_ptr] : 32'h0;
        occupancy = count;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~32'd3;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) pc <= pc + 32'd4;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr] <= pc;
            q_instr[wr_ptr] <= imem_data;
        end
    end
endmodule
